// File: rtl/mcy_seq_pkg.sv
// -----------------------------------------------------------------------------
// mcy_seq_pkg
// Shared types for the mutation-campaign sequencer.
//   mcy_seq_state_e : campaign controller states
//   mcy_result_t    : one killed/survived record (mutation ID, verdict, cycle)
//   make_result()   : builds a record from its three fields
// The record fields are RESULT_FIELD_W wide so one type covers every supported
// selector and counter width. Users truncate to the widths actually in use.
// -----------------------------------------------------------------------------
package mcy_seq_pkg;

    localparam int unsigned RESULT_FIELD_W = 32;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RESET  = 3'd1,
        ST_RUN    = 3'd2,
        ST_REPORT = 3'd3,
        ST_DONE   = 3'd4
    } mcy_seq_state_e;

    typedef struct packed {
        logic [RESULT_FIELD_W-1:0] mutsel;
        logic                      killed;
        logic [RESULT_FIELD_W-1:0] cycle;
    } mcy_result_t;

    function automatic mcy_result_t make_result(
        input logic [RESULT_FIELD_W-1:0] mutsel,
        input logic                      killed,
        input logic [RESULT_FIELD_W-1:0] cycle
    );
        mcy_result_t r;
        r.mutsel = mutsel;
        r.killed = killed;
        r.cycle  = cycle;
        return r;
    endfunction

endpackage

// File: rtl/mcy_mutant_sequencer_if.sv
// -----------------------------------------------------------------------------
// mcy_mutant_sequencer_if
// Result-record channel of the mutation sequencer (valid/ready handshake).
//   valid  : record valid (sequencer -> host)
//   ready  : record accepted (host -> sequencer)
//   mutsel : mutation ID of the record
//   killed : 1 = mismatch detected, 0 = survived
//   cycle  : run-cycle index of the first mismatch, or run length if survived
// Modports: master = sequencer side, slave = host side.
// -----------------------------------------------------------------------------
interface mcy_mutant_sequencer_if #(
    parameter int unsigned MUTSEL_W = 8,
    parameter int unsigned CYCLE_W  = 16
);

    logic                valid;
    logic                ready;
    logic [MUTSEL_W-1:0] mutsel;
    logic                killed;
    logic [CYCLE_W-1:0]  cycle;

    modport master (
        output valid,
        output mutsel,
        output killed,
        output cycle,
        input  ready
    );

    modport slave (
        input  valid,
        input  mutsel,
        input  killed,
        input  cycle,
        output ready
    );

endinterface

// File: rtl/mcy_seq_counter.sv
// -----------------------------------------------------------------------------
// mcy_seq_counter
// Loadable up-counter with a terminal-count flag.
//   clk_i      : clock
//   rst_i      : synchronous active-high reset (count -> 0)
//   load_i     : load load_val_i (has priority over en_i)
//   load_val_i : value to load
//   en_i       : increment by one
//   term_i     : terminal value to compare against
//   count_o    : current count
//   tc_o       : count_o == term_i
// -----------------------------------------------------------------------------
module mcy_seq_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    input  logic [W-1:0] term_i,
    output logic [W-1:0] count_o,
    output logic         tc_o
);

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_o <= '0;
        end else if (load_i) begin
            count_o <= load_val_i;
        end else if (en_i) begin
            count_o <= count_o + W'(1);
        end
    end

    assign tc_o = (count_o == term_i);

endmodule

// File: rtl/mcy_mutant_sequencer.sv
// -----------------------------------------------------------------------------
// mcy_mutant_sequencer
// Campaign controller for the mutation-coverage miter. Steps the uut mutsel
// through [first, last], holding both cores in reset for RESET_CYCLES cycles,
// running them for run_cycles cycles while watching the miter mismatch flag,
// then emitting one killed/survived record per mutant.
//   clk_i, rst_i     : clock, synchronous active-high reset
//   start_i          : start campaign (honoured only in IDLE/DONE)
//   mut_first_i      : first mutation ID (0 is clamped to 1)
//   mut_last_i       : last mutation ID, inclusive
//   run_cycles_i     : post-reset cycles per mutant (0 treated as 1)
//   mismatch_i       : miter compare-failure flag, looked at only in RUN
//   core_rst_no      : active-low reset to both cores
//   mutsel_o         : selector to the uut core
//   busy_o, done_o   : campaign in progress / finished (level)
//   res              : result-record channel (master side)
// All outputs are registered.
// -----------------------------------------------------------------------------
module mcy_mutant_sequencer
    import mcy_seq_pkg::*;
#(
    parameter int unsigned MUTSEL_W     = 8,
    parameter int unsigned CYCLE_W      = 16,
    parameter int unsigned RESET_CYCLES = 4
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                start_i,
    input  logic [MUTSEL_W-1:0] mut_first_i,
    input  logic [MUTSEL_W-1:0] mut_last_i,
    input  logic [CYCLE_W-1:0]  run_cycles_i,
    input  logic                mismatch_i,
    output logic                core_rst_no,
    output logic [MUTSEL_W-1:0] mutsel_o,
    output logic                busy_o,
    output logic                done_o,
    mcy_mutant_sequencer_if.master res
);

    localparam int unsigned RST_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

    mcy_seq_state_e state_q, state_d;

    // Latched campaign parameters.
    logic [MUTSEL_W-1:0] last_q;
    logic [CYCLE_W-1:0]  run_q;

    // Registered outputs.
    logic                core_rst_n_q;
    logic [MUTSEL_W-1:0] mutsel_q;
    logic                busy_q;
    logic                done_q;
    logic                res_valid_q;
    logic [MUTSEL_W-1:0] res_mutsel_q;
    logic                res_killed_q;
    logic [CYCLE_W-1:0]  res_cycle_q;

    // Decoded controls.
    logic [MUTSEL_W-1:0] first_c;
    logic [CYCLE_W-1:0]  run_c;
    logic                start_go;
    logic                range_empty;
    logic                handshake;
    logic                run_end;
    logic                rst_tc;
    logic                run_tc;
    logic [CYCLE_W-1:0]  run_count;

    // ------------------------------------------------------------------
    // Counters: each holds 0 outside its own state and counts inside it,
    // so entering the state always starts from a cleared count.
    // ------------------------------------------------------------------
    mcy_seq_counter #(.W(RST_W)) u_rst_cnt (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (state_q != ST_RESET),
        .load_val_i ('0),
        .en_i       (state_q == ST_RESET),
        .term_i     (RST_W'(RESET_CYCLES - 1)),
        .count_o    (),
        .tc_o       (rst_tc)
    );

    mcy_seq_counter #(.W(CYCLE_W)) u_run_cnt (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (state_q != ST_RUN),
        .load_val_i ('0),
        .en_i       (state_q == ST_RUN),
        .term_i     (run_q - CYCLE_W'(1)),
        .count_o    (run_count),
        .tc_o       (run_tc)
    );

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it
        // unassigned, which would infer a latch.
        state_d     = state_q;
        first_c     = (mut_first_i == '0) ? MUTSEL_W'(1) : mut_first_i;
        run_c       = (run_cycles_i == '0) ? CYCLE_W'(1) : run_cycles_i;
        start_go    = 1'b0;
        range_empty = (first_c > mut_last_i);
        handshake   = (state_q == ST_REPORT) && res_valid_q && res.ready;
        // Mismatch is only meaningful while the cores run out of reset.
        run_end     = (state_q == ST_RUN) && (mismatch_i || run_tc);

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_i) begin
                    start_go = 1'b1;
                    state_d  = range_empty ? ST_DONE : ST_RESET;
                end
            end
            ST_RESET: begin
                if (rst_tc) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (run_end) state_d = ST_REPORT;
            end
            ST_REPORT: begin
                // Compare against last before incrementing so last = max ID
                // terminates instead of wrapping.
                if (handshake) state_d = (mutsel_q == last_q) ? ST_DONE : ST_RESET;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // ------------------------------------------------------------------
    // Registered outputs and datapath. Status outputs are derived from the
    // next state so they line up with the state register.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_q       <= '0;
            run_q        <= '0;
            core_rst_n_q <= 1'b0;
            mutsel_q     <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            res_valid_q  <= 1'b0;
            res_mutsel_q <= '0;
            res_killed_q <= 1'b0;
            res_cycle_q  <= '0;
        end else begin
            core_rst_n_q <= (state_d == ST_RUN);
            busy_q       <= (state_d == ST_RESET) || (state_d == ST_RUN) ||
                            (state_d == ST_REPORT);
            done_q       <= (state_d == ST_DONE);
            res_valid_q  <= (state_d == ST_REPORT);

            if (start_go) begin
                last_q <= mut_last_i;
                run_q  <= run_c;
                if (!range_empty) mutsel_q <= first_c;
            end else if (handshake && (mutsel_q != last_q)) begin
                mutsel_q <= mutsel_q + MUTSEL_W'(1);
            end

            // Record is frozen from capture until the next mutant ends RUN.
            if (run_end) begin
                res_mutsel_q <= mutsel_q;
                res_killed_q <= mismatch_i;
                res_cycle_q  <= mismatch_i ? run_count : run_q;
            end
        end
    end

    assign core_rst_no = core_rst_n_q;
    assign mutsel_o    = mutsel_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign res.valid   = res_valid_q;
    assign res.mutsel  = res_mutsel_q;
    assign res.killed  = res_killed_q;
    assign res.cycle   = res_cycle_q;

endmodule

// File: tb/tb_mcy_mutant_sequencer.sv
// -----------------------------------------------------------------------------
// tb_mcy_mutant_sequencer
// Directed campaigns with hand-computed records. Stimulus pushes expected
// records into a scoreboard queue; a monitor pops and compares on every
// accepted record. Status and timing points are checked inline.
// -----------------------------------------------------------------------------
module tb_mcy_mutant_sequencer;
    import mcy_seq_pkg::*;

    localparam int MW = 8;
    localparam int CW = 16;
    localparam int RC = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [MW-1:0] first;
    logic [MW-1:0] last;
    logic [CW-1:0] run;
    logic          mismatch;
    logic          core_rst_n;
    logic [MW-1:0] mutsel;
    logic          busy;
    logic          done;

    mcy_mutant_sequencer_if #(.MUTSEL_W(MW), .CYCLE_W(CW)) res_if ();

    mcy_mutant_sequencer #(
        .MUTSEL_W     (MW),
        .CYCLE_W      (CW),
        .RESET_CYCLES (RC)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .start_i      (start),
        .mut_first_i  (first),
        .mut_last_i   (last),
        .run_cycles_i (run),
        .mismatch_i   (mismatch),
        .core_rst_no  (core_rst_n),
        .mutsel_o     (mutsel),
        .busy_o       (busy),
        .done_o       (done),
        .res          (res_if)
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    mcy_result_t exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
        end
    endtask

    task automatic timeout(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    // Scoreboard monitor: a record is accepted at the posedge following a
    // negedge where valid and ready are both high.
    always @(negedge clk) begin : monitor
        mcy_result_t e;
        if (rst === 1'b0 && res_if.valid === 1'b1 && res_if.ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_record: mutsel %0d killed %0d cycle %0d, scoreboard empty",
                         res_if.mutsel, res_if.killed, res_if.cycle);
            end else begin
                e = exp_q.pop_front();
                check("rec_mutsel", 32'(res_if.mutsel), e.mutsel);
                check("rec_killed", 32'(res_if.killed), 32'(e.killed));
                check("rec_cycle",  32'(res_if.cycle),  e.cycle);
            end
        end
    end

    task automatic start_campaign(input int f, input int l, input int r);
        @(posedge clk);
        #1;
        start = 1'b1;
        first = MW'(f);
        last  = MW'(l);
        run   = CW'(r);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string name);
        int i = 0;
        while (done !== 1'b1 && i < budget) begin
            @(negedge clk);
            i++;
        end
        if (done !== 1'b1) timeout(name);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_core_rst_n"}, 32'(core_rst_n),    32'd0);
        check({tag, "_mutsel"},     32'(mutsel),        32'd0);
        check({tag, "_busy"},       32'(busy),          32'd0);
        check({tag, "_done"},       32'(done),          32'd0);
        check({tag, "_valid"},      32'(res_if.valid),  32'd0);
        check({tag, "_res_mutsel"}, 32'(res_if.mutsel), 32'd0);
        check({tag, "_res_killed"}, 32'(res_if.killed), 32'd0);
        check({tag, "_res_cycle"},  32'(res_if.cycle),  32'd0);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int cnt;
        int i;
        rst          = 1'b1;
        start        = 1'b0;
        first        = '0;
        last         = '0;
        run          = '0;
        mismatch     = 1'b0;
        res_if.ready = 1'b1;

        // Reset values.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;

        // Empty range straight from IDLE: DONE one cycle after start.
        @(negedge clk);
        check("empty_done_before", 32'(done), 32'd0);
        start_campaign(4, 2, 5);
        @(negedge clk);
        check("empty_done", 32'(done), 32'd1);
        check("empty_busy", 32'(busy), 32'd0);
        for (int k = 0; k < 3; k++) begin
            check("empty_no_valid", 32'(res_if.valid), 32'd0);
            @(negedge clk);
        end

        // Three survivors, no backpressure.
        exp_q.push_back(make_result(32'd1, 1'b0, 32'd10));
        exp_q.push_back(make_result(32'd2, 1'b0, 32'd10));
        exp_q.push_back(make_result(32'd3, 1'b0, 32'd10));
        start_campaign(1, 3, 10);
        check("t1_busy", 32'(busy), 32'd1);
        wait_done(200, "t1_done");
        check("t1_done", 32'(done), 32'd1);
        check("t1_busy_end", 32'(busy), 32'd0);
        check("t1_mutsel_end", 32'(mutsel), 32'd3);
        check("t1_core_parked", 32'(core_rst_n), 32'd0);
        check("t1_sb_empty", 32'(exp_q.size()), 32'd0);

        // Killed mutant: mismatch sampled in the 8th RUN cycle (index 7).
        exp_q.push_back(make_result(32'd5, 1'b1, 32'd7));
        start_campaign(5, 5, 20);
        i = 0;
        while (core_rst_n !== 1'b1 && i < 20) begin
            @(negedge clk);
            i++;
        end
        if (core_rst_n !== 1'b1) timeout("t2_run_entry");
        repeat (7) @(negedge clk);
        mismatch = 1'b1;
        @(negedge clk);
        mismatch = 1'b0;
        check("t2_report_valid", 32'(res_if.valid), 32'd1);
        check("t2_left_run", 32'(core_rst_n), 32'd0);
        wait_done(50, "t2_done");
        check("t2_sb_empty", 32'(exp_q.size()), 32'd0);

        // First ID 0 clamps to 1; mismatch during reset is ignored.
        exp_q.push_back(make_result(32'd1, 1'b0, 32'd4));
        start_campaign(0, 1, 4);
        mismatch = 1'b1;
        cnt = 0;
        i   = 0;
        while (i < 20) begin
            @(negedge clk);
            i++;
            if (core_rst_n === 1'b0) begin
                cnt++;
                if (cnt == RC) mismatch = 1'b0;
            end else begin
                break;
            end
        end
        mismatch = 1'b0;
        check("t3_reset_low_cycles", 32'(cnt), 32'(RC));
        check("t3_mutsel", 32'(mutsel), 32'd1);
        wait_done(50, "t3_done");
        check("t3_mutsel_end", 32'(mutsel), 32'd1);
        check("t3_sb_empty", 32'(exp_q.size()), 32'd0);

        // Top of range with backpressure: stable record, no wrap past 255.
        exp_q.push_back(make_result(32'd254, 1'b0, 32'd3));
        exp_q.push_back(make_result(32'd255, 1'b0, 32'd3));
        res_if.ready = 1'b0;
        start_campaign(254, 255, 3);
        i = 0;
        while (res_if.valid !== 1'b1 && i < 30) begin
            @(negedge clk);
            i++;
        end
        if (res_if.valid !== 1'b1) timeout("t5_valid");
        for (int k = 0; k < 5; k++) begin
            check("t5_hold_valid",  32'(res_if.valid),  32'd1);
            check("t5_hold_mutsel", 32'(res_if.mutsel), 32'd254);
            check("t5_hold_killed", 32'(res_if.killed), 32'd0);
            check("t5_hold_cycle",  32'(res_if.cycle),  32'd3);
            check("t5_hold_sel",    32'(mutsel),        32'd254);
            @(posedge clk);
            #1;
        end
        res_if.ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("t5_valid_drop", 32'(res_if.valid), 32'd0);
        check("t5_next_sel", 32'(mutsel), 32'd255);
        wait_done(50, "t5_done");
        repeat (3) @(negedge clk);
        check("t5_mutsel_nowrap", 32'(mutsel), 32'd255);
        check("t5_done_held", 32'(done), 32'd1);
        check("t5_sb_empty", 32'(exp_q.size()), 32'd0);

        // Reset in RUN of mutant 2; in-flight record discarded, restart.
        exp_q.push_back(make_result(32'd1, 1'b0, 32'd10));
        start_campaign(1, 3, 10);
        i = 0;
        while (!(mutsel === MW'(2) && core_rst_n === 1'b1) && i < 100) begin
            @(negedge clk);
            i++;
        end
        if (!(mutsel === MW'(2) && core_rst_n === 1'b1)) timeout("t6_run2");
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("midrst");
        rst = 1'b0;
        @(negedge clk);
        check("t6_idle_busy", 32'(busy), 32'd0);
        check("t6_sb_empty", 32'(exp_q.size()), 32'd0);
        exp_q.push_back(make_result(32'd1, 1'b0, 32'd2));
        start_campaign(1, 1, 2);
        @(negedge clk);
        check("t6_restart_sel", 32'(mutsel), 32'd1);
        check("t6_restart_busy", 32'(busy), 32'd1);
        wait_done(50, "t6_done");
        @(negedge clk);
        check("final_sb_empty", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mcy_mutant_sequencer.md
# mcy_mutant_sequencer

Campaign controller for the cv32e40p mutation-coverage miter. It steps the `mutsel` selector of the mutated core through a programmed range of mutation IDs. For each mutant it holds both cores in reset, runs them for a fixed number of cycles, and watches the miter's aggregated output-mismatch flag. It emits one killed/survived result record per mutant over a valid/ready channel. It sits between a campaign host and the two `cv32e40p_core` instances: it drives their `rst_ni` and the uut `mutsel`, and it consumes the OR of all output-compare failures.

## Interface
- `MUTSEL_W`, default 8: width of the mutation selector. ID 0 is the unmutated reference.
- `CYCLE_W`, default 16: width of the run-length and cycle counters.
- `RESET_CYCLES`, default 4: number of cycles the cores are held in reset per mutant. Must be at least 1.

Ports:
- `clk_i`  in  1  clock. The block uses one clock only.
- `rst_i`  in  1  reset, synchronous, active-high.
- `start_i`  in  1  start campaign. Sampled only in IDLE or DONE.
- `mut_first_i`  in  MUTSEL_W  first mutation ID. Latched at start.
- `mut_last_i`  in  MUTSEL_W  last mutation ID, inclusive. Latched at start.
- `run_cycles_i`  in  CYCLE_W  number of post-reset cycles per mutant. Latched at start.
- `mismatch_i`  in  1  miter compare-failure flag, combinational OR of all output compares.
- `core_rst_no`  out  1  active-low reset to both cores.
- `mutsel_o`  out  MUTSEL_W  selector to the uut core.
- `busy_o`  out  1  campaign in progress.
- `done_o`  out  1  campaign finished. This is a level signal.
- `res_valid_o`  out  1  result record valid.
- `res_ready_i`  in  1  result record accepted.
- `res_mutsel_o`  out  MUTSEL_W  mutation ID of the record.
- `res_killed_o`  out  1  1 = mismatch detected, 0 = survived.
- `res_cycle_o`  out  CYCLE_W  run-cycle index of the first mismatch. Equals the latched run length if the mutant survived.

## Operation
- States are IDLE, RESET, RUN, REPORT and DONE.
- IDLE or DONE, with `start_i` asserted:
  - Latch the inputs.
  - A latched first ID of 0 is clamped to 1.
  - A latched run length of 0 is treated as 1.
  - If first > last (after the clamp), go to DONE and emit no records.
  - Otherwise set `mutsel_o` to first and go to RESET.
- RESET:
  - `core_rst_no` = 0 for exactly RESET_CYCLES cycles.
  - Then clear the cycle counter and go to RUN.
- RUN:
  - `core_rst_no` = 1 and the cycle counter increments every cycle.
  - If `mismatch_i` = 1, capture killed = 1 and cycle = current counter value, then go to REPORT.
  - If the counter reaches run−1 without a mismatch, capture killed = 0 and cycle = run, then go to REPORT.
  - A mismatch on the final cycle counts as killed.
- REPORT:
  - `res_valid_o` = 1 and the record fields are stable.
  - `core_rst_no` = 0, which parks the cores in reset.
  - On `res_valid_o && res_ready_i`:
    - If `mutsel_o` == last, go to DONE.
    - Otherwise increment `mutsel_o` and go to RESET.
  - The compare against last happens before the increment, so last = 2^MUTSEL_W−1 never wraps.
- DONE: `done_o` = 1 and `core_rst_no` = 0. The block stays in DONE until `start_i` or `rst_i`.
- `mismatch_i` is ignored outside RUN, because the miter's compares are not meaningful during core reset.
- `start_i` is ignored while `busy_o` = 1.

## Timing
- Reset values:
  - state = IDLE.
  - `core_rst_no` = 0.
  - `mutsel_o` = 0.
  - `busy_o` = 0, `done_o` = 0, `res_valid_o` = 0.
  - `res_mutsel_o` = 0, `res_killed_o` = 0, `res_cycle_o` = 0.
- All outputs are registered.
- `busy_o` = 1 in RESET, RUN and REPORT.
- `start_i` in cycle t gives RESET in t+1, with `core_rst_no` low in cycles t+1 … t+RESET_CYCLES.
- Run length:
  - A surviving mutant spends exactly run cycles in RUN.
  - A killed mutant leaves RUN in the cycle after the mismatch is sampled.
  - `res_valid_o` rises in the first REPORT cycle.
- Per-mutant overhead: RESET_CYCLES + RUN cycles + 1 REPORT cycle minimum, plus any backpressure.
- `res_valid_o` must not drop, and the record fields must not change, until the handshake completes.
- After the handshake, `res_valid_o` is 0 in the next cycle.
- `rst_i` mid-campaign returns the block to IDLE in the next cycle with all outputs at their reset values. An in-flight record is discarded.
- `rst_i` has priority over `start_i`.

## Structure
- Package `mcy_seq_pkg` holds:
  - the state enum `mcy_seq_state_e`;
  - a result struct `mcy_result_t` containing mutsel, killed and cycle.
- Sub-module `mcy_seq_counter` is a loadable up-counter with a terminal-count flag. It is instantiated twice:
  - once for the RESET_CYCLES countdown;
  - once for the run-cycle index.
- The miter instantiates this block and feeds `mismatch_i` from the OR of its output compares.

## Test plan
- first=1, last=3, run=10, `mismatch_i` held 0, `res_ready_i` = 1 → three records (1,0,10), (2,0,10), (3,0,10); then `done_o` = 1 and `busy_o` = 0.
- first=5, last=5, run=20, `mismatch_i` pulsed in the 8th RUN cycle → record (5,1,7); the block leaves RUN the next cycle.
- first=0, last=1, run=4 → only mutsel 1 is run. `core_rst_no` is low for exactly 4 cycles before RUN.
- first=4, last=2 → DONE one cycle after start, with no `res_valid_o` ever.
- first=254, last=255, `res_ready_i` held low 5 cycles → record fields are stable throughout; `mutsel_o` ends at 255, then DONE with no wrap.
- `rst_i` asserted in RUN of mutant 2 → next cycle IDLE with all outputs at their reset values. A new `start_i` restarts from the first ID.
